// File: rtl/readout_tx_pulse_sequencer_if.sv
// readout_tx_pulse_sequencer_if
// Bundles every non-clock/reset signal of the readout TX pulse sequencer.
//   slave  modport : the sequencer itself (takes config/requests, drives
//                    the envelope read address, samples and RX strobes)
//   master modport : whatever drives the sequencer (controller/bench side)
// Signals:
//   tx_config_wr_en/addr/data : config write port (0=length, 1=amplitude, 2=tail)
//   meas_req_in / meas_req_ready_out / busy_out : request handshake
//   env_mem_rd_addr_out / env_mem_rd_data_in    : external envelope memory port
//   valid_out, i_out, q_out                     : scaled I/Q sample stream
//   start_count_out / finish_count_out          : RX integration window strobes
interface readout_tx_pulse_sequencer_if #(
    parameter int DATA_WIDTH           = 16,
    parameter int ENV_MEM_ADDR_WIDTH   = 10,
    parameter int TX_CONFIG_ADDR_WIDTH = 2
);
    logic                            tx_config_wr_en;
    logic [TX_CONFIG_ADDR_WIDTH-1:0] tx_config_wr_addr;
    logic [DATA_WIDTH-1:0]           tx_config_wr_data;
    logic                            meas_req_in;
    logic                            meas_req_ready_out;
    logic [ENV_MEM_ADDR_WIDTH-1:0]   env_mem_rd_addr_out;
    logic [2*DATA_WIDTH-1:0]         env_mem_rd_data_in;
    logic                            valid_out;
    logic [DATA_WIDTH-1:0]           i_out;
    logic [DATA_WIDTH-1:0]           q_out;
    logic                            start_count_out;
    logic                            finish_count_out;
    logic                            busy_out;

    modport slave (
        input  tx_config_wr_en, tx_config_wr_addr, tx_config_wr_data,
        input  meas_req_in, env_mem_rd_data_in,
        output meas_req_ready_out, env_mem_rd_addr_out,
        output valid_out, i_out, q_out,
        output start_count_out, finish_count_out, busy_out
    );

    modport master (
        output tx_config_wr_en, tx_config_wr_addr, tx_config_wr_data,
        output meas_req_in, env_mem_rd_data_in,
        input  meas_req_ready_out, env_mem_rd_addr_out,
        input  valid_out, i_out, q_out,
        input  start_count_out, finish_count_out, busy_out
    );
endinterface

// File: rtl/readout_tx_pulse_sequencer.sv
// readout_tx_pulse_sequencer
// On an accepted measurement request, streams the stored I/Q envelope from
// an external memory, scales it by a programmable Q1.15 amplitude and emits
// start/finish strobes bracketing the RX bin-counting window.
// Ports:
//   clk  : single clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : readout_tx_pulse_sequencer_if.slave (config port, request
//          handshake, envelope read port, sample stream, RX strobes)
module readout_tx_pulse_sequencer #(
    parameter int DATA_WIDTH           = 16,
    parameter int ENV_MEM_NUM_ENTRY    = 1024,
    parameter int ENV_MEM_ADDR_WIDTH   = 10,
    parameter int TX_CONFIG_ADDR_WIDTH = 2
) (
    input logic                          clk,
    input logic                          rst,
    readout_tx_pulse_sequencer_if.slave  bus
);
    localparam int LEN_WIDTH = ENV_MEM_ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] MAX_LEN   = DATA_WIDTH'(ENV_MEM_NUM_ENTRY);
    localparam logic [DATA_WIDTH-1:0] AMP_RESET = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, PLAY, DRAIN, TAIL} state_t;

    state_t                        state;
    logic                          ready;
    logic                          finish;
    logic [ENV_MEM_ADDR_WIDTH-1:0] addr;
    logic [ENV_MEM_ADDR_WIDTH-1:0] last_addr;
    logic                          drain_cnt;
    logic [DATA_WIDTH-1:0]         tail_cnt;
    logic [DATA_WIDTH-1:0]         tail_snap;
    logic [DATA_WIDTH-1:0]         amp_snap;

    logic [DATA_WIDTH-1:0]         cfg_pulse_length;
    logic [DATA_WIDTH-1:0]         cfg_amplitude;
    logic [DATA_WIDTH-1:0]         cfg_tail_cycles;

    logic [LEN_WIDTH-1:0]          clamped_len;
    logic [LEN_WIDTH-1:0]          last_len;
    logic                          accept;

    logic                          data_valid;
    logic [1:0]                    start_pipe;
    logic                          start_reg;
    logic                          valid_reg;
    logic [DATA_WIDTH-1:0]         i_reg;
    logic [DATA_WIDTH-1:0]         q_reg;

    // Full signed product, floor shift by DATA_WIDTH-1; the shifted value
    // only overflows when the top two product bits differ.
    function automatic logic [DATA_WIDTH-1:0] scale(
        input logic [DATA_WIDTH-1:0] env,
        input logic [DATA_WIDTH-1:0] amp
    );
        logic signed [2*DATA_WIDTH-1:0] env_ext;
        logic signed [2*DATA_WIDTH-1:0] amp_ext;
        logic signed [2*DATA_WIDTH-1:0] prod;
        env_ext = {{DATA_WIDTH{env[DATA_WIDTH-1]}}, env};
        amp_ext = {{DATA_WIDTH{amp[DATA_WIDTH-1]}}, amp};
        prod    = env_ext * amp_ext;
        if (prod[2*DATA_WIDTH-1] == prod[2*DATA_WIDTH-2]) begin
            return prod[2*DATA_WIDTH-2:DATA_WIDTH-1];
        end else if (!prod[2*DATA_WIDTH-1]) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    endfunction

    assign accept = bus.meas_req_in & ready;

    // Lengths beyond the memory depth are clamped so the address never wraps.
    always_comb begin
        clamped_len = cfg_pulse_length[LEN_WIDTH-1:0];
        if (cfg_pulse_length > MAX_LEN) begin
            clamped_len = LEN_WIDTH'(ENV_MEM_NUM_ENTRY);
        end
        last_len = clamped_len - LEN_WIDTH'(1);
    end

    // Config registers; a write in the acceptance cycle lands after the
    // snapshot is taken and therefore only affects the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pulse_length <= '0;
            cfg_amplitude    <= AMP_RESET;
            cfg_tail_cycles  <= '0;
        end else if (bus.tx_config_wr_en) begin
            case (bus.tx_config_wr_addr)
                TX_CONFIG_ADDR_WIDTH'(0): cfg_pulse_length <= bus.tx_config_wr_data;
                TX_CONFIG_ADDR_WIDTH'(1): cfg_amplitude    <= bus.tx_config_wr_data;
                TX_CONFIG_ADDR_WIDTH'(2): cfg_tail_cycles  <= bus.tx_config_wr_data;
                default: ;
            endcase
        end
    end

    // Main sequencer. TAIL lasts tail_snap+1 cycles so that finish is
    // still a busy cycle and ready rises the cycle after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            finish    <= 1'b0;
            addr      <= '0;
            last_addr <= '0;
            drain_cnt <= 1'b0;
            tail_cnt  <= '0;
            tail_snap <= '0;
            amp_snap  <= AMP_RESET;
        end else begin
            case (state)
                IDLE: begin
                    finish <= 1'b0;
                    if (accept) begin
                        amp_snap  <= cfg_amplitude;
                        tail_snap <= cfg_tail_cycles;
                        last_addr <= last_len[ENV_MEM_ADDR_WIDTH-1:0];
                        addr      <= '0;
                        drain_cnt <= 1'b0;
                        ready     <= 1'b0;
                        state     <= (clamped_len == '0) ? DRAIN : PLAY;
                    end
                end
                PLAY: begin
                    if (addr == last_addr) begin
                        addr  <= '0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ENV_MEM_ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        drain_cnt <= 1'b0;
                        tail_cnt  <= '0;
                        finish    <= (tail_snap == '0);
                        state     <= TAIL;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                TAIL: begin
                    if (tail_cnt == tail_snap) begin
                        finish <= 1'b0;
                        ready  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tail_cnt <= tail_cnt + DATA_WIDTH'(1);
                        finish   <= ((tail_cnt + DATA_WIDTH'(1)) == tail_snap);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Sample pipeline: an address in PLAY returns data one cycle later and
    // the scaled result is registered one cycle after that. start_count
    // travels a matching 3-stage delay from acceptance, even for L=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid <= 1'b0;
            valid_reg  <= 1'b0;
            i_reg      <= '0;
            q_reg      <= '0;
            start_pipe <= '0;
            start_reg  <= 1'b0;
        end else begin
            data_valid <= (state == PLAY);
            valid_reg  <= data_valid;
            i_reg      <= data_valid ? scale(bus.env_mem_rd_data_in[DATA_WIDTH-1:0], amp_snap) : '0;
            q_reg      <= data_valid ? scale(bus.env_mem_rd_data_in[2*DATA_WIDTH-1:DATA_WIDTH], amp_snap) : '0;
            start_pipe <= {start_pipe[0], accept};
            start_reg  <= start_pipe[1];
        end
    end

    assign bus.meas_req_ready_out  = ready;
    assign bus.busy_out            = ~ready;
    assign bus.env_mem_rd_addr_out = addr;
    assign bus.valid_out           = valid_reg;
    assign bus.i_out               = i_reg;
    assign bus.q_out               = q_reg;
    assign bus.start_count_out     = start_reg;
    assign bus.finish_count_out    = finish;
endmodule

// File: tb/tb_readout_tx_pulse_sequencer.sv
// tb_readout_tx_pulse_sequencer
// Self-checking bench for readout_tx_pulse_sequencer: models the external
// envelope memory (one-cycle read latency), drives config writes and
// requests, and compares every output against an independent model.
module tb_readout_tx_pulse_sequencer;
    localparam int DW  = 16;
    localparam int N   = 1024;
    localparam int AW  = 10;
    localparam int CAW = 2;
    localparam logic [46:0] IDLE_VEC = {1'b1, 46'b0};

    typedef struct {
        logic [15:0] env_i;
        logic [15:0] env_q;
        logic [15:0] amp;
        logic [15:0] exp_i;
        logic [15:0] exp_q;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [2*DW-1:0] env_mem [0:N-1];
    vec_t vecs [8];

    always #5 clk = ~clk;

    readout_tx_pulse_sequencer_if #(
        .DATA_WIDTH(DW), .ENV_MEM_ADDR_WIDTH(AW), .TX_CONFIG_ADDR_WIDTH(CAW)
    ) bus ();

    readout_tx_pulse_sequencer #(
        .DATA_WIDTH(DW), .ENV_MEM_NUM_ENTRY(N),
        .ENV_MEM_ADDR_WIDTH(AW), .TX_CONFIG_ADDR_WIDTH(CAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // External envelope memory with registered read.
    always @(posedge clk) begin
        bus.env_mem_rd_data_in <= env_mem[bus.env_mem_rd_addr_out];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Packed as {ready, busy, valid, start, finish, addr, i, q}.
    function automatic logic [46:0] sampleOutputs();
        return {bus.meas_req_ready_out, bus.busy_out, bus.valid_out,
                bus.start_count_out, bus.finish_count_out,
                bus.env_mem_rd_addr_out, bus.i_out, bus.q_out};
    endfunction

    function automatic logic [15:0] scaleModel(input logic [15:0] env, input logic [15:0] amp);
        longint p;
        longint r;
        p = longint'($signed(env)) * longint'($signed(amp));
        r = p >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    task automatic writeConfig(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.tx_config_wr_en   = 1'b1;
        bus.tx_config_wr_addr = a;
        bus.tx_config_wr_data = d;
        @(negedge clk);
        bus.tx_config_wr_en   = 1'b0;
    endtask

    // Waits (bounded) for ready, raises the request and returns right
    // after the acceptance edge T0. Optionally writes pulse_length in the
    // acceptance cycle itself.
    task automatic startRequest(input bit with_write, input logic [15:0] wdata);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.meas_req_ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready timeout: actual 0 required 1");
        end
        bus.meas_req_in = 1'b1;
        if (with_write) begin
            bus.tx_config_wr_en   = 1'b1;
            bus.tx_config_wr_addr = 2'd0;
            bus.tx_config_wr_data = wdata;
        end
        @(posedge clk);
    endtask

    // Checks every cycle T0+1..T0+L+4+E against the timing model.
    task automatic checkPulse(input int id, input int len_req, input int tail,
                              input logic [15:0] amp, input bit hold);
        int leff;
        int total;
        logic        e_rdy, e_vld, e_st, e_fin;
        int          e_addr;
        logic [15:0] e_i, e_q;
        leff  = (len_req > N) ? N : len_req;
        total = leff + 4 + tail;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            e_rdy  = (c == total);
            e_vld  = (c >= 3) && (c <= leff + 2);
            e_st   = (c == 3);
            e_fin  = (c == leff + 3 + tail);
            e_addr = (c <= leff) ? c - 1 : 0;
            e_i    = e_vld ? scaleModel(env_mem[c-3][15:0], amp)  : 16'h0;
            e_q    = e_vld ? scaleModel(env_mem[c-3][31:16], amp) : 16'h0;
            checkOutput($sformatf("pulse%0d cycle%0d {rdy,bsy,vld,st,fin,addr,i,q}", id, c),
                        sampleOutputs(),
                        {e_rdy, ~e_rdy, e_vld, e_st, e_fin, 10'(e_addr), e_i, e_q});
            if (c == 1) begin
                bus.tx_config_wr_en = 1'b0;
                if (!hold) bus.meas_req_in = 1'b0;
            end
        end
    endtask

    // One table record: single-sample pulse (L=1, E=0) with given amplitude.
    task automatic applyStimulus(input vec_t v);
        env_mem[0] = {v.env_q, v.env_i};
        writeConfig(2'd1, v.amp);
        startRequest(1'b0, 16'h0);
    endtask

    task automatic runVector(input int idx, input vec_t v);
        applyStimulus(v);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.meas_req_in = 1'b0;
            if (c == 3) begin
                checkOutput($sformatf("vector%0d {vld,i,q}", idx),
                            {bus.valid_out, bus.i_out, bus.q_out},
                            {1'b1, v.exp_i, v.exp_q});
            end
        end
    endtask

    initial begin
        vecs[0] = '{env_i:16'h7FFE, env_q:16'h0001, amp:16'h4000, exp_i:16'h3FFF, exp_q:16'h0000};
        vecs[1] = '{env_i:16'h8000, env_q:16'h0001, amp:16'h8000, exp_i:16'h7FFF, exp_q:16'hFFFF};
        vecs[2] = '{env_i:16'h7FFF, env_q:16'h8000, amp:16'h7FFF, exp_i:16'h7FFE, exp_q:16'h8001};
        vecs[3] = '{env_i:16'h1234, env_q:16'hFEDC, amp:16'h0000, exp_i:16'h0000, exp_q:16'h0000};
        vecs[4] = '{env_i:16'h0005, env_q:16'hFFFB, amp:16'hFFFF, exp_i:16'hFFFF, exp_q:16'h0000};
        vecs[5] = '{env_i:16'hFFFF, env_q:16'h0003, amp:16'h4000, exp_i:16'hFFFF, exp_q:16'h0001};
        vecs[6] = '{env_i:16'h7FFF, env_q:16'hFFFF, amp:16'h8000, exp_i:16'h8001, exp_q:16'h0001};
        vecs[7] = '{env_i:16'h1000, env_q:16'hF000, amp:16'h2000, exp_i:16'h0400, exp_q:16'hFC00};

        rst                   = 1'b1;
        bus.tx_config_wr_en   = 1'b0;
        bus.tx_config_wr_addr = '0;
        bus.tx_config_wr_data = '0;
        bus.meas_req_in       = 1'b0;
        for (int k = 0; k < N; k++) env_mem[k] = '0;

        // Reset state and first cycle after release.
        repeat (3) @(negedge clk);
        checkOutput("reset state", sampleOutputs(), IDLE_VEC);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after reset release", sampleOutputs(), IDLE_VEC);

        // Basic pulse: L=4, amplitude 0.5, E=2.
        $display("[TB] basic pulse");
        for (int k = 0; k < 4; k++) env_mem[k] = {16'(k + 1), 16'h7FFE};
        writeConfig(2'd0, 16'd4);
        writeConfig(2'd1, 16'h4000);
        writeConfig(2'd2, 16'd2);
        startRequest(1'b0, 16'h0);
        checkPulse(1, 4, 2, 16'h4000, 1'b0);

        // Arithmetic table.
        $display("[TB] arithmetic table");
        writeConfig(2'd0, 16'd1);
        writeConfig(2'd2, 16'd0);
        for (int i = 0; i < 8; i++) runVector(i, vecs[i]);

        // Zero-length, zero-tail pulse.
        $display("[TB] L=0 E=0");
        writeConfig(2'd0, 16'd0);
        startRequest(1'b0, 16'h0);
        checkPulse(2, 0, 0, 16'h2000, 1'b0);

        // Over-long pulse clamps to the memory depth.
        $display("[TB] length clamp");
        for (int k = 0; k < N; k++) env_mem[k] = {16'(k) ^ 16'hA5C3, 16'(k * 37)};
        writeConfig(2'd0, 16'd2000);
        writeConfig(2'd1, 16'h7FFF);
        writeConfig(2'd2, 16'd1);
        startRequest(1'b0, 16'h0);
        checkPulse(3, 2000, 1, 16'h7FFF, 1'b0);

        // Write in the acceptance cycle; request held high through busy.
        $display("[TB] snapshot and held request");
        writeConfig(2'd0, 16'd3);
        writeConfig(2'd1, 16'h4000);
        writeConfig(2'd2, 16'd0);
        startRequest(1'b1, 16'd8);
        checkPulse(4, 3, 0, 16'h4000, 1'b1);
        @(posedge clk);
        checkPulse(5, 8, 0, 16'h4000, 1'b0);

        // Asynchronous reset in the middle of PLAY.
        $display("[TB] reset mid-play");
        writeConfig(2'd2, 16'd3);
        startRequest(1'b0, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.meas_req_in = 1'b0;
        end
        checkOutput("mid-play addr", 64'(bus.env_mem_rd_addr_out), 64'd3);
        #2 rst = 1'b1;
        #1 checkOutput("async reset outputs", sampleOutputs(), IDLE_VEC);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset idle%0d", c), sampleOutputs(), IDLE_VEC);
        end
        startRequest(1'b0, 16'h0);
        checkPulse(6, 0, 0, 16'h7FFF, 1'b0);
        env_mem[0] = {16'h8000, 16'h7FFF};
        writeConfig(2'd0, 16'd1);
        startRequest(1'b0, 16'h0);
        checkPulse(7, 1, 0, 16'h7FFF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
